hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

- Pipeline hazard and forwarding controller for the 5-stage core.
- Tracks the destination and source registers of the instructions in ID, EX, MEM and WB in internal shadow records.
- Drives the 2-bit operand-select lines of the two EX-stage 3:1 operand muxes.
- Generates load-use stalls and branch flushes for the IF/ID and ID/EX pipeline registers.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- STALL_CW, 16, width of the stall-statistics counter.

Ports:
- clk, in, 1, core clock; all state updates on the rising edge.
- rst_n, in, 1, synchronous active-low reset.
- id_valid, in, 1, ID holds a real instruction.
- id_rs1 / id_rs2, in, REG_AW, ID source register addresses.
- id_use_rs1 / id_use_rs2, in, 1, the ID instruction reads that source.
- id_rd, in, REG_AW, ID destination register.
- id_reg_write, in, 1, the ID instruction writes id_rd.
- id_mem_read, in, 1, the ID instruction is a load.
- ex_branch_taken, in, 1, the branch or jump resolved in EX is redirecting the PC.
- fwd_a / fwd_b, out, 2, operand select: 00 register file, 01 WB result, 10 MEM ALU result; 11 is never driven.
- stall_if, out, 1, hold the PC.
- stall_id, out, 1, hold IF/ID.
- bubble_ex, out, 1, load a NOP into ID/EX.
- flush_id, out, 1, clear IF/ID.
- stall_cnt, out, STALL_CW, saturating count of load-use stall cycles.

## Operation
- Record layout, held once per stage EX, MEM and WB: valid, rs1, rs2, use_rs1, use_rs2, rd, reg_write, mem_read.
- Record "writes r" is true when valid && reg_write && rd == r && r != 0.
- Record advance, each edge:
  - EX ← ID inputs, MEM ← EX, WB ← MEM.
  - When bubble_ex = 1, EX ← an invalid record.
- Forwarding for fwd_a (fwd_b is identical with rs2/use_rs2):
  - 10 if the EX record uses rs1 and MEM writes EX.rs1;
  - else 01 if WB writes EX.rs1;
  - else 00.
  - MEM has priority over WB; register x0 is never forwarded.
- Load-use hazard condition:
  - the EX record is valid, mem_read = 1, rd != 0;
  - id_valid = 1;
  - (id_use_rs1 and id_rs1 == EX.rd) or (id_use_rs2 and id_rs2 == EX.rd).
- Load-use response: stall_if = stall_id = bubble_ex = 1 for exactly one cycle.
- Flush response: when ex_branch_taken = 1, flush_id = 1 and bubble_ex = 1.
- Branch priority: ex_branch_taken overrides a simultaneous load-use condition, so stall_if = stall_id = 0 in that cycle. The stalled instruction is wrong-path.
- stall_cnt increments once per cycle in which stall_if = 1 and saturates at all-ones.

## Timing
- fwd_a and fwd_b are combinational from registered records only, so they are valid early in the EX cycle with zero added latency.
- stall and flush outputs are combinational from the ID inputs and the EX record, and are valid in the same cycle.
- A load with an immediately dependent instruction costs 1 stall cycle. After the bubble, the dependent instruction sees fwd = 01, taking the load data from WB.
- A taken branch produces bubbles in the two following stage slots: flush_id and bubble_ex are both asserted in the resolve cycle.
- Reset:
  - all records are invalid;
  - fwd_a = fwd_b = 00;
  - stall_if, stall_id, bubble_ex and flush_id are 0;
  - stall_cnt = 0.
- Reset asserted mid-stall clears all state at that edge; no stall persists past reset.
- Both MEM and WB writing the same register: MEM wins, since it holds the newest value.

## Structure
- Shared core package holds:
  - the fwd_sel_t enum (FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10);
  - the REG_AW constant;
  - the hazard record typedef.
- The operand muxes consume fwd_sel_t directly.
- One sub-module: fwd_select, the combinational per-operand priority compare, instantiated twice (A and B).

## Test plan
- add x5 in MEM, sub x6,x5,x1 in EX → fwd_a = 10, fwd_b = 00.
- add x5 in WB, nothing in MEM, and in EX or x7,x2,x5 → fwd_b = 01.
- lw x5 in EX, add x8,x5,x5 in ID → one cycle with stall_if = stall_id = bubble_ex = 1 and stall_cnt 0→1.
  - Following EX cycle: fwd_a = fwd_b = 01.
- Same lw/add pair with ex_branch_taken = 1 → flush_id = 1, bubble_ex = 1, stall_if = 0, stall_cnt unchanged.
- Writer to x0 in MEM, EX reads x0 → fwd_a = 00.
  - Also: MEM and WB both write x9 → fwd = 10.
- rst_n low during a load-use stall → next cycle all outputs 0 and the records are invalid.
  - stall_cnt preset near max (0xFFFF) with further stalls → holds 0xFFFF.

Source files
------------

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared definitions for the hazard/forwarding controller: operand-select
// encoding, register-address width and the per-stage hazard record.
package hazard_fwd_unit_pkg;

  localparam int REG_AW = 5;

  // Operand-select encoding consumed directly by the EX-stage operand muxes.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Shadow copy of the register usage of one in-flight instruction.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } hazard_rec_t;

  localparam hazard_rec_t REC_INVALID = '0;

  // True when the record will write register r; x0 is never a real target.
  function automatic logic rec_writes(hazard_rec_t rec, logic [REG_AW-1:0] r);
    return rec.valid && rec.reg_write && (rec.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_select.sv
// Per-operand forwarding priority compare: MEM (newest) beats WB beats the
// register file.
module fwd_select
  import hazard_fwd_unit_pkg::*;
(
  input  logic              use_src,
  input  logic [REG_AW-1:0] src,
  input  hazard_rec_t       mem_rec,
  input  hazard_rec_t       wb_rec,
  output fwd_sel_t          sel
);

  // Priority select of the operand source.
  // NOTE: sel gets a default before any branch so no latch can be inferred.
  always_comb begin
    sel = FWD_RF;
    if (use_src && rec_writes(mem_rec, src)) begin
      sel = FWD_MEM;
    end else if (rec_writes(wb_rec, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard and forwarding controller for the 5-stage core. Keeps
// shadow records for EX/MEM/WB, drives the EX operand selects, and raises
// load-use stalls and branch flushes.
module hazard_fwd_unit #(
  parameter int REG_AW   = 5,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                ex_branch_taken,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                stall_if,
  output logic                stall_id,
  output logic                bubble_ex,
  output logic                flush_id,
  output logic [STALL_CW-1:0] stall_cnt
);
  import hazard_fwd_unit_pkg::*;

  hazard_rec_t id_rec;
  hazard_rec_t ex_rec;
  hazard_rec_t mem_rec;
  hazard_rec_t wb_rec;
  fwd_sel_t    sel_a;
  fwd_sel_t    sel_b;
  logic        load_use;

  assign id_rec = '{
    valid:     id_valid,
    rs1:       id_rs1,
    rs2:       id_rs2,
    use_rs1:   id_use_rs1,
    use_rs2:   id_use_rs2,
    rd:        id_rd,
    reg_write: id_reg_write,
    mem_read:  id_mem_read
  };

  // Operand A/B selects, computed only from registered records.
  fwd_select u_fwd_a (
    .use_src (ex_rec.use_rs1),
    .src     (ex_rec.rs1),
    .mem_rec (mem_rec),
    .wb_rec  (wb_rec),
    .sel     (sel_a)
  );

  fwd_select u_fwd_b (
    .use_src (ex_rec.use_rs2),
    .src     (ex_rec.rs2),
    .mem_rec (mem_rec),
    .wb_rec  (wb_rec),
    .sel     (sel_b)
  );

  assign fwd_a = sel_a;
  assign fwd_b = sel_b;

  // Load in EX whose result the instruction in ID needs right away.
  always_comb begin
    load_use = ex_rec.valid && ex_rec.mem_read && (ex_rec.rd != '0) && id_valid &&
               ((id_use_rs1 && (id_rs1 == ex_rec.rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rec.rd)));
  end

  // Stall/flush response; a taken branch makes the stalled instruction
  // wrong-path, so it suppresses the hold but keeps the bubble.
  always_comb begin
    stall_if  = load_use && !ex_branch_taken;
    stall_id  = stall_if;
    bubble_ex = load_use || ex_branch_taken;
    flush_id  = ex_branch_taken;
  end

  // Record advance and saturating stall counter.
  // NOTE: non-blocking assignments let each stage read last cycle's value of
  // the stage before it, which is exactly the shift-register behaviour here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the records are a handful of flops, not a memory, so they are
      // reset; an invalid record is what keeps stale hazards from firing.
      ex_rec    <= REC_INVALID;
      mem_rec   <= REC_INVALID;
      wb_rec    <= REC_INVALID;
      stall_cnt <= '0;
    end else begin
      ex_rec  <= bubble_ex ? REC_INVALID : id_rec;
      mem_rec <= ex_rec;
      wb_rec  <= mem_rec;
      if (stall_if && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: a behavioural pipeline model
// predicts every cycle's outputs into a scoreboard queue, and a monitor on
// the falling edge pops and compares. Directed scenarios add fixed checks.
module tb_hazard_fwd_unit;

  localparam int REG_AW   = 5;
  localparam int STALL_CW = 6;
  localparam int CNT_MAX  = (1 << STALL_CW) - 1;

  typedef struct {
    bit v;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
    int rd;
    bit we;
    bit mr;
  } ins_t;

  typedef struct {
    int fa;
    int fb;
    bit si;
    bit sd;
    bit bx;
    bit fl;
    int cnt;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                id_valid = 1'b0;
  logic [REG_AW-1:0]   id_rs1 = '0;
  logic [REG_AW-1:0]   id_rs2 = '0;
  logic                id_use_rs1 = 1'b0;
  logic                id_use_rs2 = 1'b0;
  logic [REG_AW-1:0]   id_rd = '0;
  logic                id_reg_write = 1'b0;
  logic                id_mem_read = 1'b0;
  logic                ex_branch_taken = 1'b0;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;
  logic                stall_if;
  logic                stall_id;
  logic                bubble_ex;
  logic                flush_id;
  logic [STALL_CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  hazard_fwd_unit #(.REG_AW(REG_AW), .STALL_CW(STALL_CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .bubble_ex       (bubble_ex),
    .flush_id        (flush_id),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
  ins_t pipe[3];
  int   model_cnt;
  exp_t sb_q[$];

  // What was applied during the current cycle; consumed at the next edge.
  ins_t cur_id;
  bit   cur_taken;
  bit   cur_rst_n = 1'b0;
  exp_t cur_exp;

  function automatic ins_t nop();
    ins_t n;
    n = '{v: 0, rs1: 0, rs2: 0, u1: 0, u2: 0, rd: 0, we: 0, mr: 0};
    return n;
  endfunction

  function automatic ins_t mk(int rd, int rs1, int rs2, bit u1, bit u2, bit we, bit mr);
    ins_t n;
    n = '{v: 1, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, we: we, mr: mr};
    return n;
  endfunction

  function automatic bit writes(ins_t s, int r);
    return s.v && s.we && (s.rd == r) && (r != 0);
  endfunction

  function automatic int pick(bit uses, int r);
    if (uses && writes(pipe[1], r)) return 2;
    if (writes(pipe[2], r)) return 1;
    return 0;
  endfunction

  function automatic exp_t predict(ins_t id, bit taken);
    exp_t e;
    bit   hazard;
    ins_t ex;
    ex = pipe[0];
    hazard = ex.v && ex.mr && (ex.rd != 0) && id.v &&
             ((id.u1 && id.rs1 == ex.rd) || (id.u2 && id.rs2 == ex.rd));
    e.fa  = pick(ex.u1, ex.rs1);
    e.fb  = pick(ex.u2, ex.rs2);
    e.si  = hazard && !taken;
    e.sd  = e.si;
    e.bx  = hazard || taken;
    e.fl  = taken;
    e.cnt = model_cnt;
    return e;
  endfunction

  task automatic step(input ins_t id, input bit taken, input bit rst_level);
    @(posedge clk);
    if (!cur_rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i] = nop();
      model_cnt = 0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = cur_exp.bx ? nop() : cur_id;
      if (cur_exp.si && model_cnt < CNT_MAX) model_cnt++;
    end
    #1;
    rst_n           = rst_level;
    id_valid        = id.v;
    id_rs1          = id.rs1[REG_AW-1:0];
    id_rs2          = id.rs2[REG_AW-1:0];
    id_use_rs1      = id.u1;
    id_use_rs2      = id.u2;
    id_rd           = id.rd[REG_AW-1:0];
    id_reg_write    = id.we;
    id_mem_read     = id.mr;
    ex_branch_taken = taken;
    cur_id    = id;
    cur_taken = taken;
    cur_rst_n = rst_level;
    cur_exp   = predict(id, taken);
    sb_q.push_back(cur_exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(nop(), 1'b0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("sb_fwd_a", int'(fwd_a), e.fa);
      check("sb_fwd_b", int'(fwd_b), e.fb);
      check("sb_ctrl", int'({stall_if, stall_id, bubble_ex, flush_id}),
            int'({e.si, e.sd, e.bx, e.fl}));
      check("sb_stall_cnt", int'(stall_cnt), e.cnt);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    ins_t lw5, dep;
    lw5 = mk(5, 1, 0, 1, 0, 1, 1);
    dep = mk(8, 5, 5, 1, 1, 1, 0);

    // Reset: first edge with rst_n low clears everything.
    step(nop(), 1'b0, 1'b0);
    step(nop(), 1'b0, 1'b1);
    @(negedge clk);
    check("reset_outputs", int'({fwd_a, fwd_b, stall_if, stall_id, bubble_ex, flush_id}), 0);
    check("reset_stall_cnt", int'(stall_cnt), 0);

    // add x5 in MEM, sub x6,x5,x1 in EX.
    idle(3);
    step(mk(5, 1, 2, 1, 1, 1, 0), 1'b0, 1'b1);
    step(mk(6, 5, 1, 1, 1, 1, 0), 1'b0, 1'b1);
    step(nop(), 1'b0, 1'b1);
    @(negedge clk);
    check("mem_fwd_a", int'(fwd_a), 2);
    check("mem_fwd_b", int'(fwd_b), 0);

    // add x5 in WB, MEM empty, or x7,x2,x5 in EX.
    idle(3);
    step(mk(5, 1, 2, 1, 1, 1, 0), 1'b0, 1'b1);
    step(nop(), 1'b0, 1'b1);
    step(mk(7, 2, 5, 1, 1, 1, 0), 1'b0, 1'b1);
    step(nop(), 1'b0, 1'b1);
    @(negedge clk);
    check("wb_fwd_b", int'(fwd_b), 1);
    check("wb_fwd_a", int'(fwd_a), 0);

    // Load-use: lw x5 then add x8,x5,x5 -> one stall, then WB forwarding.
    idle(3);
    step(lw5, 1'b0, 1'b1);
    step(dep, 1'b0, 1'b1);
    @(negedge clk);
    check("lu_ctrl", int'({stall_if, stall_id, bubble_ex, flush_id}), 4'b1110);
    check("lu_cnt_before", int'(stall_cnt), 0);
    step(dep, 1'b0, 1'b1);
    @(negedge clk);
    check("lu_released", int'({stall_if, stall_id, bubble_ex}), 0);
    check("lu_cnt_after", int'(stall_cnt), 1);
    step(nop(), 1'b0, 1'b1);
    @(negedge clk);
    check("lu_fwd_ab", int'({fwd_a, fwd_b}), 4'b0101);

    // Same pair with a taken branch: flush wins over the stall.
    idle(3);
    step(lw5, 1'b0, 1'b1);
    step(dep, 1'b1, 1'b1);
    @(negedge clk);
    check("br_ctrl", int'({stall_if, stall_id, bubble_ex, flush_id}), 4'b0011);
    step(nop(), 1'b0, 1'b1);
    @(negedge clk);
    check("br_cnt", int'(stall_cnt), 1);

    // Writer to x0 in MEM: never forwarded.
    idle(3);
    step(mk(0, 1, 2, 1, 1, 1, 0), 1'b0, 1'b1);
    step(mk(6, 0, 0, 1, 1, 1, 0), 1'b0, 1'b1);
    step(nop(), 1'b0, 1'b1);
    @(negedge clk);
    check("x0_fwd_a", int'(fwd_a), 0);

    // MEM and WB both write x9: MEM wins.
    idle(3);
    step(mk(9, 1, 2, 1, 1, 1, 0), 1'b0, 1'b1);
    step(mk(9, 3, 4, 1, 1, 1, 0), 1'b0, 1'b1);
    step(mk(10, 9, 9, 1, 1, 1, 0), 1'b0, 1'b1);
    step(nop(), 1'b0, 1'b1);
    @(negedge clk);
    check("x9_fwd", int'({fwd_a, fwd_b}), 4'b1010);

    // Reset asserted during a load-use stall.
    idle(3);
    step(lw5, 1'b0, 1'b1);
    step(dep, 1'b0, 1'b0);
    step(dep, 1'b0, 1'b1);
    @(negedge clk);
    check("rst_mid_stall_out", int'({fwd_a, fwd_b, stall_if, stall_id, bubble_ex, flush_id}), 0);
    check("rst_mid_stall_cnt", int'(stall_cnt), 0);
    step(nop(), 1'b0, 1'b1);
    @(negedge clk);
    check("rst_records_invalid", int'({fwd_a, fwd_b}), 0);

    // Saturation: more load-use stalls than the counter can hold.
    for (int i = 0; i < CNT_MAX + 8; i++) begin
      step(lw5, 1'b0, 1'b1);
      step(dep, 1'b0, 1'b1);
    end
    step(nop(), 1'b0, 1'b1);
    @(negedge clk);
    check("cnt_saturated", int'(stall_cnt), CNT_MAX);

    // Randomized traffic over a small register set to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      ins_t r;
      bit   tk;
      bit   rl;
      r.v   = ($urandom_range(0, 9) < 8);
      r.rs1 = $urandom_range(0, 7);
      r.rs2 = $urandom_range(0, 7);
      r.u1  = ($urandom_range(0, 9) < 7);
      r.u2  = ($urandom_range(0, 9) < 7);
      r.rd  = $urandom_range(0, 7);
      r.we  = ($urandom_range(0, 9) < 7);
      r.mr  = ($urandom_range(0, 9) < 4);
      tk    = ($urandom_range(0, 9) == 0);
      rl    = ($urandom_range(0, 149) != 0);
      step(r, tk, rl);
    end

    idle(2);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
